// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, credit-limited request/grant fetch,
// small in-order instruction buffer with valid/ready output and PC redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PCSRC,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY
);

  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   fifo_pc_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_d [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [31:0]   fifo_instr_d [FIFO_DEPTH];

  logic [CW:0]   in_flight;
  logic          credit_ok;
  logic          grant;
  logic          pop;
  logic          push;
  logic [31:0]   rsp_addr;

  // Every granted-but-unanswered fetch reserves a buffer slot, so the FIFO never overflows.
  assign in_flight   = {1'b0, outstanding_q} + {1'b0, count_q};
  assign credit_ok   = (in_flight < DEPTH_C);
  assign IMEM_REQ    = ~RESET & ~PCSRC & credit_ok;
  assign IMEM_ADDR   = pc_q;
  assign grant       = IMEM_REQ & IMEM_GNT;
  assign INSTR_VALID = (count_q != {CW{1'b0}});
  assign pop         = INSTR_VALID & INSTR_READY;
  assign INSTRUCTION = INSTR_VALID ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
  assign INSTR_PC    = INSTR_VALID ? fifo_pc_q[rd_ptr_q] : 32'h0000_0000;

  // With nothing left to discard, all outstanding fetches are sequential and end at pc_q-4.
  assign rsp_addr = pc_q - {{(30 - CW){1'b0}}, outstanding_q, 2'b00};

  // Next-state: PC advance, bus accounting, buffer push/pop and redirect flush.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(IMEM_RVALID);
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_instr_d  = fifo_instr_q;
    push          = 1'b0;

    if (PCSRC) begin
      pc_d      = BRANCH_TARGET & 32'hFFFF_FFFC;
      discard_d = outstanding_d;
      count_d   = {CW{1'b0}};
      rd_ptr_d  = {PW{1'b0}};
      wr_ptr_d  = {PW{1'b0}};
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end

      if (IMEM_RVALID && (discard_q != {CW{1'b0}})) begin
        discard_d = discard_q - CW'(1'b1);
        push      = 1'b0;
      end else begin
        discard_d = discard_q;
        push      = IMEM_RVALID;
      end

      if (push) begin
        fifo_pc_d[wr_ptr_q]    = rsp_addr;
        fifo_instr_d[wr_ptr_q] = IMEM_RDATA;
        wr_ptr_d               = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q          <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      discard_q     <= {CW{1'b0}};
      count_q       <= {CW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Buffer storage; contents are qualified by count_q, so no reset is needed.
  always_ff @(posedge CLK) begin
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: wait-state memory responder plus a queue-based
// reference model of the fetch stream, driven by directed phases and random traffic.
module tb_fetch_unit;

  localparam int          D   = 4;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        PCSRC = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0000_0000;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0000_0000;
  logic [31:0] INSTRUCTION;
  logic [31:0] INSTR_PC;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
    .CLK(CLK), .RESET(RESET), .PCSRC(PCSRC), .BRANCH_TARGET(BRANCH_TARGET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .INSTRUCTION(INSTRUCTION), .INSTR_PC(INSTR_PC), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // memory responder state
  int unsigned mq_due[$];
  logic [31:0] mq_addr[$];
  int unsigned last_due = 0;
  int unsigned cyc = 0;
  int          gnt_cnt = 0;

  // reference model state
  logic [31:0] m_pc = RPC;
  logic [31:0] pend_a[$];
  bit          pend_drop[$];
  logic [31:0] fq_a[$];
  logic [31:0] fq_d[$];
  logic [31:0] stream_pc = RPC;
  logic [31:0] hs_pc[$];
  int unsigned hs_cyc[$];

  int          gnt_mode = 0;  // 0 always, 1 alternate, 2 random
  int          rdy_mode = 0;  // 0 ready, 1 stalled, 2 random
  int unsigned lat_lo = 1;
  int unsigned lat_hi = 1;
  bit          chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1357;
  endfunction

  task automatic step(input logic rst, input logic ps, input logic [31:0] tgt);
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_ins;
    logic [31:0] exp_ipc;
    logic [31:0] pa;
    bit          pd;
    int unsigned due;
    @(negedge CLK);
    RESET         = rst;
    PCSRC         = ps;
    BRANCH_TARGET = tgt;
    case (gnt_mode)
      0:       IMEM_GNT = 1'b1;
      1:       IMEM_GNT = (cyc % 2 == 1);
      default: IMEM_GNT = 1'($urandom_range(0, 1));
    endcase
    case (rdy_mode)
      0:       INSTR_READY = 1'b1;
      1:       INSTR_READY = 1'b0;
      default: INSTR_READY = 1'($urandom_range(0, 1));
    endcase
    IMEM_RVALID = (mq_due.size() != 0) && (mq_due[0] <= cyc);
    IMEM_RDATA  = IMEM_RVALID ? memfn(mq_addr[0]) : $urandom();

    exp_req   = !rst && !ps && ((pend_a.size() + fq_a.size()) < D);
    exp_valid = (fq_a.size() != 0);
    exp_ins   = exp_valid ? fq_d[0] : 32'h0000_0013;
    exp_ipc   = exp_valid ? fq_a[0] : 32'h0000_0000;
    #1;
    if (chk_en) begin
      check_eq("imem_req", IMEM_REQ, exp_req);
      check_eq("imem_addr", IMEM_ADDR, m_pc);
      check_eq("instr_valid", INSTR_VALID, exp_valid);
      check_eq("instruction", INSTRUCTION, exp_ins);
      check_eq("instr_pc", INSTR_PC, exp_ipc);
      if (!rst && exp_valid && INSTR_READY) begin
        check_eq("stream_pc", INSTR_PC, stream_pc);
        hs_pc.push_back(INSTR_PC);
        hs_cyc.push_back(cyc);
        stream_pc = stream_pc + 32'd4;
      end
    end

    if (rst) begin
      mq_due.delete();
      mq_addr.delete();
      last_due = cyc;
    end else begin
      if (IMEM_RVALID) begin
        void'(mq_due.pop_front());
        void'(mq_addr.pop_front());
      end
      if (IMEM_REQ && IMEM_GNT) begin
        due = cyc + $urandom_range(lat_lo, lat_hi);
        if (due <= last_due) due = last_due + 1;
        mq_due.push_back(due);
        mq_addr.push_back(IMEM_ADDR);
        last_due = due;
        gnt_cnt++;
      end
    end

    if (rst) begin
      m_pc = RPC;
      pend_a.delete();
      pend_drop.delete();
      fq_a.delete();
      fq_d.delete();
      stream_pc = RPC;
    end else begin
      if (exp_valid && INSTR_READY) begin
        void'(fq_a.pop_front());
        void'(fq_d.pop_front());
      end
      if (IMEM_RVALID && pend_a.size() != 0) begin
        pa = pend_a.pop_front();
        pd = pend_drop.pop_front();
        if (!pd && !ps) begin
          fq_a.push_back(pa);
          fq_d.push_back(IMEM_RDATA);
        end
      end
      if (exp_req && IMEM_GNT) begin
        pend_a.push_back(m_pc);
        pend_drop.push_back(1'b0);
        m_pc = m_pc + 32'd4;
      end
      if (ps) begin
        fq_a.delete();
        fq_d.delete();
        foreach (pend_drop[i]) pend_drop[i] = 1'b1;
        m_pc      = tgt & 32'hFFFF_FFFC;
        stream_pc = m_pc;
      end
    end
    cyc++;
  endtask

  initial begin
    int unsigned rel;
    int          w;
    logic        r_rst;
    logic        r_ps;

    // reset, then zero-wait streaming from RESET_PC
    step(1'b1, 1'b0, 32'h0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    hs_pc.delete();
    hs_cyc.delete();
    rel = cyc;
    repeat (12) step(1'b0, 1'b0, 32'h0);
    if (hs_pc.size() >= 3) begin
      check_eq("first_latency", 32'(hs_cyc[0] - rel), 32'd2);
      for (int i = 0; i < 3; i++) begin
        check_eq("seq_pc", hs_pc[i], RPC + 32'(4 * i));
        check_eq("seq_gap", 32'(hs_cyc[i] - hs_cyc[0]), 32'(i));
      end
    end else begin
      check_eq("seq_count", 32'(hs_pc.size()), 32'd3);
    end

    // consumer stalled after redirect to 0: exactly D grants, then in-order drain
    rdy_mode = 1;
    gnt_cnt  = 0;
    step(1'b0, 1'b1, 32'h0000_0000);
    repeat (10) step(1'b0, 1'b0, 32'h0);
    check_eq("stall_grants", 32'(gnt_cnt), 32'(D));
    rdy_mode = 0;
    hs_pc.delete();
    hs_cyc.delete();
    repeat (8) step(1'b0, 1'b0, 32'h0);
    if (hs_pc.size() >= D) begin
      for (int i = 0; i < D; i++) check_eq("drain_pc", hs_pc[i], 32'(4 * i));
    end else begin
      check_eq("drain_count", 32'(hs_pc.size()), 32'(D));
    end

    // alternating grant, 3-cycle latency
    gnt_mode = 1;
    lat_lo   = 3;
    lat_hi   = 3;
    repeat (40) step(1'b0, 1'b0, 32'h0);

    // redirect to 0x203 with two fetches in flight
    gnt_mode = 0;
    w = 0;
    while (pend_a.size() < 2 && w < 20) begin
      step(1'b0, 1'b0, 32'h0);
      w++;
    end
    check_eq("pend_reached", 32'(pend_a.size() >= 2), 32'd1);
    hs_pc.delete();
    hs_cyc.delete();
    rdy_mode = 1;
    step(1'b0, 1'b1, 32'h0000_0203);
    rdy_mode = 0;
    w = 0;
    while (hs_pc.size() == 0 && w < 30) begin
      step(1'b0, 1'b0, 32'h0);
      w++;
    end
    check_eq("redir_first_pc", (hs_pc.size() != 0) ? hs_pc[0] : 32'hDEAD_BEEF, 32'h0000_0200);

    // PC wrap at the top of the address space
    lat_lo = 1;
    lat_hi = 1;
    hs_pc.delete();
    hs_cyc.delete();
    rdy_mode = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    rdy_mode = 0;
    repeat (8) step(1'b0, 1'b0, 32'h0);
    if (hs_pc.size() >= 2) begin
      check_eq("wrap_pc0", hs_pc[0], 32'hFFFF_FFFC);
      check_eq("wrap_pc1", hs_pc[1], 32'h0000_0000);
    end else begin
      check_eq("wrap_count", 32'(hs_pc.size()), 32'd2);
    end

    // reset mid-stream with the buffer full
    rdy_mode = 1;
    repeat (12) step(1'b0, 1'b0, 32'h0);
    check_eq("full_valid", INSTR_VALID, 1'b1);
    step(1'b1, 1'b0, 32'h0);
    @(posedge CLK);
    #1;
    check_eq("rst_valid", INSTR_VALID, 1'b0);
    check_eq("rst_addr", IMEM_ADDR, RPC);
    check_eq("rst_req", IMEM_REQ, 1'b0);

    // random traffic
    gnt_mode = 2;
    rdy_mode = 2;
    lat_lo   = 1;
    lat_hi   = 4;
    for (int i = 0; i < 1500; i++) begin
      r_rst = ($urandom_range(0, 399) == 0);
      r_ps  = ($urandom_range(0, 19) == 0);
      step(r_rst, r_ps, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the processor; sits directly upstream of the control unit and drives the 32-bit `INSTRUCTION` word it decodes. Holds the program counter and issues in-order requests to instruction memory over a request/grant bus that tolerates wait states. Buffers returned words in a small FIFO and presents them with a valid/ready handshake. Applies PC redirects from `PCSRC`/`BRANCH_TARGET`, flushing buffered and in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `FIFO_DEPTH`, 2, instruction buffer entries; power of two, 2..8

- `CLK`  in  1  single clock; all state updates on the rising edge
- `RESET`  in  1  synchronous, active-high reset
- `PCSRC`  in  1  redirect request, sampled each cycle
- `BRANCH_TARGET`  in  32  redirect address, valid when `PCSRC`=1
- `IMEM_REQ`  out  1  fetch request
- `IMEM_ADDR`  out  32  fetch address (word aligned)
- `IMEM_GNT`  in  1  request accepted when `IMEM_REQ`&`IMEM_GNT`
- `IMEM_RVALID`  in  1  read data valid, responses in grant order
- `IMEM_RDATA`  in  32  read data
- `INSTRUCTION`  out  32  instruction to control unit
- `INSTR_PC`  out  32  address of `INSTRUCTION`
- `INSTR_VALID`  out  1  `INSTRUCTION`/`INSTR_PC` valid
- `INSTR_READY`  in  1  consumer accepts when `INSTR_VALID`&`INSTR_READY`

## Operation
- State: `PC` (32), `OUTSTANDING` (granted, response pending), `DISCARD` (pending responses to drop), FIFO of {pc, instr} with `COUNT`.
- Credit rule: `IMEM_REQ` = !`RESET`-state & !`PCSRC` & (`OUTSTANDING` + `COUNT` < `FIFO_DEPTH`). FIFO cannot overflow.
- `IMEM_ADDR` = `PC`. On grant: `PC` <= `PC` + 4 (wraps 32'hFFFF_FFFC -> 0), `OUTSTANDING`++.
- On `IMEM_RVALID`: `OUTSTANDING`--; if `DISCARD`>0 then `DISCARD`--, word dropped; else push {address of that request, `IMEM_RDATA`}.
- `INSTRUCTION`/`INSTR_PC` = FIFO head; when empty `INSTRUCTION` = 32'h0000_0013 (NOP), `INSTR_PC` = 0. `INSTR_VALID` = `COUNT`!=0. Pop on handshake.
- Redirect (`PCSRC`=1): `PC` <= {`BRANCH_TARGET`[31:2],2'b00}; FIFO flushed (`COUNT` <= 0); `DISCARD` <= `OUTSTANDING` after this cycle's grant/response accounting; `IMEM_REQ` forced 0 that cycle. A handshake in the redirect cycle still completes (consumer keeps that word). A response arriving in the redirect cycle is dropped.
- Push and pop in the same cycle at full or empty: both take effect, `COUNT` unchanged.
- Consecutive `PCSRC` cycles: last target wins; `DISCARD` recomputed each cycle.
- `RESET`: `PC`<=`RESET_PC`, `COUNT`,`OUTSTANDING`,`DISCARD`<=0. Responses arriving after a mid-operation reset are a bus protocol violation; memory must be reset together.

## Timing
- Reset values: `IMEM_REQ`=0, `IMEM_ADDR`=`RESET_PC`, `INSTR_VALID`=0, `INSTRUCTION`=32'h0000_0013, `INSTR_PC`=0.
- First `IMEM_REQ` in first cycle with `RESET`=0.
- `IMEM_REQ`/`IMEM_ADDR` depend only on registered state and `PCSRC`; no path from `IMEM_GNT`/`IMEM_RVALID`.
- Grant at cycle T, `IMEM_RVALID` at T+k (k>=1), `INSTR_VALID` at T+k+1. Best case: one instruction per cycle at k=1, `INSTR_READY`=1.
- Redirect at cycle R: first request to new target at R+1.

## Test plan
- Reset, `RESET_PC`=0x100, zero-wait memory, `INSTR_READY`=1 -> `INSTR_PC` sequence 0x100,0x104,0x108 on consecutive cycles, `INSTRUCTION` matches memory.
- `INSTR_READY`=0 for 10 cycles -> exactly `FIFO_DEPTH` grants, then `IMEM_REQ`=0; release -> words 0x0,0x4 delivered in order, no loss or duplicate.
- `IMEM_GNT` low every other cycle, k=3 latency -> `IMEM_ADDR` held stable while ungranted; output order preserved.
- `PCSRC`=1, `BRANCH_TARGET`=0x203 with 2 outstanding -> both responses dropped, `INSTR_VALID`=0 until first word from 0x200, `INSTR_PC`=0x200.
- `PC`=0xFFFF_FFFC -> next request to 0x0000_0000.
- `RESET` asserted mid-stream with full FIFO -> next cycle `INSTR_VALID`=0, `IMEM_ADDR`=`RESET_PC`.
